// File: rtl/pipe_pkg.sv
// Shared types and default constants for the elastic pipeline-stage register.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    localparam logic [15:0] NOP_INSTR_DEF = 16'hB000;
    localparam logic [15:0] BUBBLE_PC_DEF = 16'h0000;

    function automatic logic [1:0] state_occupancy(input state_e s);
        case (s)
            ONE:     state_occupancy = 2'd1;
            TWO:     state_occupancy = 2'd2;
            default: state_occupancy = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One instruction+PC holding register with load enable and synchronous clear-to-bubble.
module pipe_entry_reg
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter logic [PC_W-1:0]    BUBBLE_PC = PC_W'(BUBBLE_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               clear,
    input  logic [INSTR_W-1:0] d_instr,
    input  logic [PC_W-1:0]    d_pc,
    output logic [INSTR_W-1:0] q_instr,
    output logic [PC_W-1:0]    q_pc
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    // Clear wins over load so a flush always leaves a bubble behind.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear) begin
            instr_d = NOP_INSTR;
            pc_d    = BUBBLE_PC;
        end else if (load) begin
            instr_d = d_instr;
            pc_d    = d_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= BUBBLE_PC;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign q_instr = instr_q;
    assign q_pc    = pc_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer; in_ready depends only on state.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 16,
    parameter int                 PC_W      = 16,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF),
    parameter logic [PC_W-1:0]    BUBBLE_PC = PC_W'(BUBBLE_PC_DEF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [1:0]         occupancy
);

    state_e state_q, state_d;

    logic               in_fire, out_fire;
    logic               head_load, head_clear, head_from_skid;
    logic               skid_load, skid_clear;
    logic [INSTR_W-1:0] head_d_instr, skid_instr;
    logic [PC_W-1:0]    head_d_pc, skid_pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d        = state_q;
        head_load      = 1'b0;
        head_clear     = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d   = ONE;
                        head_load = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_load = 1'b1;
                    end else if (in_fire) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (out_fire) begin
                        state_d    = EMPTY;
                        head_clear = 1'b1;
                    end
                end
                TWO: begin
                    // Draining the head promotes the skid entry; the input is blocked here.
                    if (out_fire) begin
                        state_d        = ONE;
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_d    = EMPTY;
                    head_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        occupancy = state_occupancy(state_q);
        unique case (state_q)
            ONE: begin
                out_valid = 1'b1;
            end
            TWO: begin
                out_valid = 1'b1;
                in_ready  = 1'b0;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
        endcase
    end

    assign head_d_instr = head_from_skid ? skid_instr : in_instr;
    assign head_d_pc    = head_from_skid ? skid_pc    : in_pc;

    pipe_entry_reg #(
        .INSTR_W   (INSTR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR),
        .BUBBLE_PC (BUBBLE_PC)
    ) u_head (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (head_load),
        .clear   (head_clear),
        .d_instr (head_d_instr),
        .d_pc    (head_d_pc),
        .q_instr (out_instr),
        .q_pc    (out_pc)
    );

    pipe_entry_reg #(
        .INSTR_W   (INSTR_W),
        .PC_W      (PC_W),
        .NOP_INSTR (NOP_INSTR),
        .BUBBLE_PC (BUBBLE_PC)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (skid_load),
        .clear   (skid_clear),
        .d_instr (in_instr),
        .d_pc    (in_pc),
        .q_instr (skid_instr),
        .q_pc    (skid_pc)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus random traffic against a queue model.
module tb_pipe_stage_skid;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready;
    logic [15:0] in_instr, in_pc;
    logic        in_ready, out_valid;
    logic [15:0] out_instr, out_pc;
    logic [1:0]  occupancy;

    logic        flush32, in_valid32, out_ready32;
    logic [31:0] in_instr32, in_pc32;
    logic        in_ready32, out_valid32;
    logic [31:0] out_instr32, out_pc32;
    logic [1:0]  occupancy32;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mq [$];
    logic [63:0] mq32 [$];

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .occupancy (occupancy)
    );

    pipe_stage_skid #(
        .INSTR_W   (32),
        .PC_W      (32),
        .NOP_INSTR (32'h0000_0013),
        .BUBBLE_PC (32'h0000_0000)
    ) dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush32),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .in_instr  (in_instr32),
        .in_pc     (in_pc32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .out_instr (out_instr32),
        .out_pc    (out_pc32),
        .occupancy (occupancy32)
    );

    // Advance one clock on the 16-bit stage and update the FIFO model.
    task automatic apply();
        bit inf, outf;
        inf  = in_valid && (mq.size() < 2);
        outf = out_ready && (mq.size() > 0);
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (outf) void'(mq.pop_front());
            if (inf) mq.push_back({in_instr, in_pc});
        end
        #1;
    endtask

    task automatic apply32();
        bit inf, outf;
        inf  = in_valid32 && (mq32.size() < 2);
        outf = out_ready32 && (mq32.size() > 0);
        @(posedge clk);
        if (flush32) mq32.delete();
        else begin
            if (outf) void'(mq32.pop_front());
            if (inf) mq32.push_back({in_instr32, in_pc32});
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 16'h1234; in_pc = 16'h0040;
        out_ready = 1'b1;
        flush32 = 1'b0; in_valid32 = 1'b1; in_instr32 = 32'hDEAD_BEEF; in_pc32 = 32'h100;
        out_ready32 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks += 7;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        if (out_instr !== 16'hB000) begin n_fail++; $display("FAIL reset_out_instr got %h want b000", out_instr); end
        if (out_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_out_pc got %h want 0000", out_pc); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
        if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        if (out_instr32 !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_out_instr32 got %h want 00000013", out_instr32); end
        if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid32 got %0b want 0", out_valid32); end
        in_valid = 1'b0; in_valid32 = 1'b0;
        mq.delete(); mq32.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 16'h1111; in_pc = 16'h0002;
        apply();
        n_checks += 3;
        if (out_instr !== 16'h1111) begin n_fail++; $display("FAIL stream_a_instr got %h want 1111", out_instr); end
        if (out_pc !== 16'h0002) begin n_fail++; $display("FAIL stream_a_pc got %h want 0002", out_pc); end
        if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_a_occ got %0d want 1", occupancy); end
        in_instr = 16'h2222; in_pc = 16'h0004;
        apply();
        n_checks += 3;
        if (out_instr !== 16'h2222) begin n_fail++; $display("FAIL stream_b_instr got %h want 2222", out_instr); end
        if (out_pc !== 16'h0004) begin n_fail++; $display("FAIL stream_b_pc got %h want 0004", out_pc); end
        if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_b_occ got %0d want 1", occupancy); end
        in_valid = 1'b0;
        apply();
        n_checks += 2;
        if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stream_drain_occ got %0d want 0", occupancy); end
        if (out_instr !== 16'hB000) begin n_fail++; $display("FAIL stream_drain_instr got %h want b000", out_instr); end
    endtask

    task automatic test_backpressure();
        logic [15:0] want_seq [3];
        want_seq[0] = 16'h1111; want_seq[1] = 16'h2222; want_seq[2] = 16'h3333;
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'h1111; in_pc = 16'h0010;
        apply();
        in_instr = 16'h2222; in_pc = 16'h0012;
        apply();
        n_checks += 3;
        if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_full_occ got %0d want 2", occupancy); end
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got %0b want 0", in_ready); end
        if (out_instr !== 16'h1111) begin n_fail++; $display("FAIL bp_full_instr got %h want 1111", out_instr); end
        in_instr = 16'h3333; in_pc = 16'h0014;
        repeat (2) apply();
        n_checks += 2;
        if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_hold_occ got %0d want 2", occupancy); end
        if (out_instr !== 16'h1111) begin n_fail++; $display("FAIL bp_hold_instr got %h want 1111", out_instr); end
        out_ready = 1'b1;
        // Head A leaves; C is still blocked since the stage was full.
        apply();
        n_checks++;
        if (out_instr !== want_seq[1]) begin n_fail++; $display("FAIL bp_order_b got %h want %h", out_instr, want_seq[1]); end
        apply();
        in_valid = 1'b0;
        n_checks += 2;
        if (out_instr !== want_seq[2]) begin n_fail++; $display("FAIL bp_order_c got %h want %h", out_instr, want_seq[2]); end
        if (out_pc !== 16'h0014) begin n_fail++; $display("FAIL bp_order_c_pc got %h want 0014", out_pc); end
        apply();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'hAAAA; in_pc = 16'h0020;
        apply();
        out_ready = 1'b1; in_instr = 16'hBBBB; in_pc = 16'h0022;
        apply();
        in_valid = 1'b0;
        n_checks += 3;
        if (out_instr !== 16'hBBBB) begin n_fail++; $display("FAIL simul_instr got %h want bbbb", out_instr); end
        if (out_pc !== 16'h0022) begin n_fail++; $display("FAIL simul_pc got %h want 0022", out_pc); end
        if (occupancy !== 2'd1) begin n_fail++; $display("FAIL simul_occ got %0d want 1", occupancy); end
        apply();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 16'hC001; in_pc = 16'h0030;
        apply();
        in_instr = 16'hC002; in_pc = 16'h0032;
        apply();
        flush = 1'b1; out_ready = 1'b1; in_instr = 16'hC003; in_pc = 16'h0034;
        apply();
        flush = 1'b0; in_valid = 1'b0;
        n_checks += 5;
        if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", occupancy); end
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %0b want 0", out_valid); end
        if (out_instr !== 16'hB000) begin n_fail++; $display("FAIL flush_instr got %h want b000", out_instr); end
        if (out_pc !== 16'h0000) begin n_fail++; $display("FAIL flush_pc got %h want 0000", out_pc); end
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got %0b want 1", in_ready); end
        for (int i = 0; i < 4; i++) begin
            apply();
            n_checks++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost cycle %0d got valid %0b instr %h want 0", i, out_valid, out_instr); end
        end
    endtask

    task automatic test_random();
        logic [15:0] e_instr, e_pc;
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_instr  = 16'($urandom);
            in_pc     = 16'($urandom);
            apply();
            e_instr = (mq.size() > 0) ? mq[0][31:16] : 16'hB000;
            e_pc    = (mq.size() > 0) ? mq[0][15:0]  : 16'h0000;
            n_checks++;
            if (out_valid !== (mq.size() != 0) || out_instr !== e_instr || out_pc !== e_pc ||
                in_ready !== (mq.size() < 2) || occupancy !== 2'(mq.size())) begin
                n_fail++;
                $display("FAIL random cycle %0d got v=%0b i=%h p=%h r=%0b o=%0d want v=%0b i=%h p=%h r=%0b o=%0d",
                         i, out_valid, out_instr, out_pc, in_ready, occupancy,
                         mq.size() != 0, e_instr, e_pc, mq.size() < 2, mq.size());
            end
        end
        flush = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 16'h7777; in_pc = 16'h0050;
        repeat (2) apply();
        #2 rst_n = 1'b0;
        #1;
        n_checks += 2;
        if (occupancy !== 2'd0) begin n_fail++; $display("FAIL midreset_occ got %0d want 0", occupancy); end
        if (out_instr !== 16'hB000) begin n_fail++; $display("FAIL midreset_instr got %h want b000", out_instr); end
        mq.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_param32();
        logic [31:0] e_instr, e_pc;
        for (int i = 0; i < 120; i++) begin
            in_valid32  = 1'($urandom_range(0, 1));
            out_ready32 = 1'($urandom_range(0, 1));
            flush32     = ($urandom_range(0, 19) == 0);
            in_instr32  = $urandom;
            in_pc32     = $urandom;
            apply32();
            e_instr = (mq32.size() > 0) ? mq32[0][63:32] : 32'h0000_0013;
            e_pc    = (mq32.size() > 0) ? mq32[0][31:0]  : 32'h0000_0000;
            n_checks++;
            if (out_valid32 !== (mq32.size() != 0) || out_instr32 !== e_instr || out_pc32 !== e_pc ||
                occupancy32 !== 2'(mq32.size())) begin
                n_fail++;
                $display("FAIL param32 cycle %0d got v=%0b i=%h p=%h o=%0d want v=%0b i=%h p=%h o=%0d",
                         i, out_valid32, out_instr32, out_pc32, occupancy32,
                         mq32.size() != 0, e_instr, e_pc, mq32.size());
            end
        end
        flush32 = 1'b0; out_ready32 = 1'b0; in_valid32 = 1'b1;
        in_instr32 = 32'hCAFE_F00D; in_pc32 = 32'h8000_0004;
        repeat (2) apply32();
        flush32 = 1'b1;
        apply32();
        flush32 = 1'b0; in_valid32 = 1'b0;
        n_checks += 2;
        if (out_instr32 !== 32'h0000_0013) begin n_fail++; $display("FAIL param32_flush_instr got %h want 00000013", out_instr32); end
        if (occupancy32 !== 2'd0) begin n_fail++; $display("FAIL param32_flush_occ got %0d want 0", occupancy32); end
        out_ready32 = 1'b1; in_valid32 = 1'b1;
        in_instr32 = 32'h89AB_CDEF; in_pc32 = 32'hFFFF_FFFC;
        apply32();
        in_valid32 = 1'b0;
        n_checks += 2;
        if (out_instr32 !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL param32_pass_instr got %h want 89abcdef", out_instr32); end
        if (out_pc32 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL param32_pass_pc got %h want fffffffc", out_pc32); end
        apply32();
        n_checks++;
        if (out_instr32 !== 32'h0000_0013) begin n_fail++; $display("FAIL param32_drain_instr got %h want 00000013", out_instr32); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_random();
        test_param32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
